wb_trace_fifo: RTL and testbench

//  Trace buffer downstream of the core's write-back stage (after the write-back result mux).

---
 rtl/wb_trace_fifo.sv | 86 ++++++++
 tb/tb_wb_trace_fifo.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/wb_trace_fifo.sv
// Trace FIFO behind the write-back stage: captures {ts, dest reg, data} on
// every qualifying register write and drains it over a valid/ready stream.
// The head entry sits in a registered output stage, so a push becomes
// visible on the edge after it is captured.
module wb_trace_fifo #(
  parameter int DEPTH       = 16,
  parameter int TS_WIDTH    = 16,
  parameter bit FILTER_ZERO = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      capture_en,
  input  logic                      wb_en,
  input  logic [4:0]                wb_addr,
  input  logic [31:0]               wb_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TS_WIDTH+36:0]      out_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [15:0]               drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = TS_WIDTH + 37;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [TS_WIDTH-1:0] ts;
  logic [EW-1:0]       mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]       count_nxt;
  logic [EW-1:0]       entry, head_nxt;
  logic                push_req, pop, full, push_acc, drop;

  // Push/pop qualification and next-state of occupancy and head entry.
  always_comb begin
    entry      = {ts, wb_addr, wb_data};
    push_req   = capture_en & wb_en & ~(FILTER_ZERO & (wb_addr == 5'd0));
    pop        = out_valid & out_ready;
    full       = (count == FULL_CNT);
    // A full FIFO still accepts when the head leaves in the same cycle.
    push_acc   = push_req & (~full | pop);
    drop       = push_req & full & ~pop;
    count_nxt  = count + CW'(push_acc) - CW'(pop);
    rd_ptr_nxt = rd_ptr + AW'(pop);
    // If the new head is the slot being written this cycle, take the
    // incoming entry directly; the storage array is not updated until the edge.
    if (push_acc && (rd_ptr_nxt == wr_ptr))
      head_nxt = entry;
    else
      head_nxt = mem[rd_ptr_nxt];
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && push_acc)
      mem[wr_ptr] <= entry;
  end

  // Timestamp, pointers, occupancy, output stage and drop accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts        <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      ts        <= ts + 1'b1;
      wr_ptr    <= wr_ptr + AW'(push_acc);
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      if (count_nxt != '0)
        out_data <= head_nxt;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF)
          drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_wb_trace_fifo.sv
// Scoreboard bench: a queue-based model updates on each rising edge from the
// driven inputs, a monitor on the falling edge compares the DUT outputs.
// A second instance with a 4-bit timestamp shares the same stimulus.
module tb_wb_trace_fifo;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        capture_en = 1'b0, wb_en = 1'b0, out_ready = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;

  logic        out_valid, overflow, out_valid4, overflow4;
  logic [52:0] out_data;
  logic [40:0] out_data4;
  logic [4:0]  count, count4;
  logic [15:0] drop_cnt, drop_cnt4;

  always #5 clk = ~clk;

  wb_trace_fifo #(.DEPTH(DEPTH), .TS_WIDTH(16), .FILTER_ZERO(1'b1)) u_dut (
    .clk(clk), .rst(rst), .capture_en(capture_en), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .count(count),
    .overflow(overflow), .drop_cnt(drop_cnt));

  wb_trace_fifo #(.DEPTH(DEPTH), .TS_WIDTH(4), .FILTER_ZERO(1'b1)) u_dut4 (
    .clk(clk), .rst(rst), .capture_en(capture_en), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid4),
    .out_ready(out_ready), .out_data(out_data4), .count(count4),
    .overflow(overflow4), .drop_cnt(drop_cnt4));

  typedef struct {
    logic [15:0] ts;
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_ts;
  logic        m_ovf;
  logic [15:0] m_drops;
  logic [52:0] m_last;
  logic [40:0] m_last4;
  bit          armed = 0;
  int          errors = 0, checks = 0;
  bit          saw_wrap = 0;

  // Reference model: whole-entry queue, updated at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_ts = 0; m_ovf = 0; m_drops = 0; m_last = '0; m_last4 = '0;
      armed = 1;
    end else if (armed) begin
      bit popped, req;
      ent_t e;
      popped = (q.size() > 0) && out_ready;
      req = capture_en && wb_en && (wb_addr != 0);
      if (popped) void'(q.pop_front());
      if (req) begin
        if (q.size() < DEPTH) begin
          e.ts = m_ts; e.a = wb_addr; e.d = wb_data;
          q.push_back(e);
        end else begin
          m_ovf = 1;
          if (m_drops != 16'hFFFF) m_drops = m_drops + 1;
        end
      end
      m_ts = m_ts + 1;
      if (q.size() > 0) begin
        m_last  = {q[0].ts, q[0].a, q[0].d};
        m_last4 = {q[0].ts[3:0], q[0].a, q[0].d};
        if (q[0].ts[3:0] == 4'd0 && q[0].ts != 0) saw_wrap = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every observable output against the model mid-cycle.
  always @(negedge clk) begin
    if (armed) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("count", 64'(count), 64'(q.size()));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
      chk("out_data", out_data[52:0] >> 0 == m_last ? 64'd0 : 64'd1, 64'd0);
      if (out_data !== m_last)
        $display("  out_data got %h expected %h", out_data, m_last);
      chk("out_data_ts4", 64'(out_data4), 64'(m_last4));
      chk("out_valid_ts4", 64'(out_valid4), 64'(q.size() > 0));
      chk("count_ts4", 64'(count4), 64'(q.size()));
    end
  end

  task automatic step(input logic ce, input logic en, input logic [4:0] a,
                      input logic [31:0] d, input logic rdy);
    capture_en = ce; wb_en = en; wb_addr = a; wb_data = d; out_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 5'd0, 32'd0, rdy);
  endtask

  initial begin
    // T1 reset for two edges, then T2: write at ts=3 held, then one pop.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(3, 1'b0);
    step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    // T3: register-0 filter and capture disabled.
    step(1'b1, 1'b1, 5'd0, 32'h11111111, 1'b0);
    step(1'b0, 1'b1, 5'd7, 32'h22222222, 1'b0);
    idle(1, 1'b0);
    // T4: fill, overflow by three, T5: full push+pop, then drain.
    for (int i = 0; i < DEPTH + 3; i++)
      step(1'b1, 1'b1, 5'(i % 31 + 1), 32'hA000_0000 + 32'(i), 1'b0);
    step(1'b1, 1'b1, 5'd9, 32'h1234, 1'b1);
    idle(DEPTH + 2, 1'b1);
    // T6: random traffic, long enough for the 4-bit timestamp to wrap.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 2) != 0);
    // Heavy-push burst with sparse reads to revisit the full boundary.
    for (int i = 0; i < 60; i++)
      step(1'b1, 1'b1, 5'($urandom_range(1, 31)), $urandom, $urandom_range(0, 3) == 0);
    // Reset mid-operation discards everything.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 5'd3, 32'(i), 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b1, 5'd4, 32'hFFFF, 1'b1);
    rst = 1'b0;
    idle(3, 1'b1);
    for (int i = 0; i < 30; i++)
      step(1'b1, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 1) == 1);
    idle(DEPTH + 2, 1'b1);
    checks++;
    if (!saw_wrap) begin
      errors++;
      $display("FAIL ts_wrap_seen: got 0 expected 1");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
